argmax_struct: RTL and testbench
================================

// Module: argmax_struct
// PURPOSE
//   Registered arg-max over ten unsigned 8-bit operands.
//   Outputs the largest value and the index (0..9) of the input that holds it.
//   Built structurally as a balanced tree of 2-input compare/select cells.
//   Leaf block for selection/classification datapaths, e.g. picking the winning class score.
// PARAMETERS
//   DATA_W  8   operand width; unsigned
//   N_IN    10  number of operands; localparam, fixed by the port list
//   IDX_W   4   index width; localparam, must be at least ceil(log2(N_IN))
// PORTS
//   clk      in   1       clock; all state updates on its rising edge
//   rst      in   1       synchronous reset, active-high
//   x0..x9   in   DATA_W  operands; xK carries index K
//   ind_max  out  IDX_W   index of the maximum operand
//   max_num  out  DATA_W  value of the maximum operand
// BEHAVIOUR
//   - Compare is unsigned magnitude (0x80 > 0x7F).
//   - Ties: lowest index wins. Every compare cell takes the lower-index candidate on
//     port A and selects A when A >= B.
//   - Compare tree is purely combinational.
//   - Its result is captured in output registers at the rising clk edge.
//   - Latency is 1 cycle: inputs applied before edge n appear on the outputs after edge n.
//   - Throughput is one new operand set per cycle.
//   - Reset: when rst=1 at a clk edge, ind_max=0 and max_num=0 at that edge, regardless of inputs.
//   - Reset asserted mid-stream discards the in-flight result.
//   - First valid output follows the first edge with rst=0.
//   - All inputs equal: ind_max=0, max_num=that value.
//   - All inputs zero: ind_max=0, max_num=0.
//     This is indistinguishable from the reset state, which is acceptable.
//   - ind_max is never greater than 9.
//   - No X propagation for known inputs; no latches.
// CONFIGURATION
//   ARGMAX_VALID_EN defined:
//     - Adds port in_valid (in, 1) and port out_valid (out, 1).
//     - Output registers load only when in_valid=1; otherwise they hold their value.
//     - out_valid is the registered in_valid (1-cycle latency).
//     - out_valid resets to 0.
//   ARGMAX_VALID_EN undefined:
//     - No handshake ports.
//     - Output registers load on every cycle in which rst=0.
// STRUCTURE
//   Package argmax_pkg:
//     - DATA_W, N_IN, IDX_W
//     - typedef struct packed {logic [IDX_W-1:0] idx; logic [DATA_W-1:0] val;} cand_t
//   Sub-module argmax_cmp2:
//     - Combinational; inputs cand_t a, cand_t b; output cand_t y.
//     - y = (a.val >= b.val) ? a : b
//   Tree (lower-index candidate always on port a):
//     L1: (0,1) (2,3) (4,5) (6,7) (8,9)
//     L2: (01,23) (45,67); 89 passes through
//     L3: (0-3,4-7)
//     L4: (0-7,89) -> output registers
// TESTING
//   1. x0..x9 = 01,8F,49,09,8F,49,F1,9F,69,4D -> ind_max=6, max_num=F1 (one cycle later)
//   2. x0..x9 = 05,8B,C1,18,16,4D,61,99,8B,49 -> ind_max=2, max_num=C1;
//      then x0..x9 = B5,8D,4D,0F,8E,4A,03,9E,66,6D -> ind_max=0, max_num=B5 (back-to-back)
//   3. x0..x9 = 01,0C,0A,0D,0D,0A,05,04,03,4D -> ind_max=9, max_num=4D (last index wins)
//   4. Ties: all inputs 80 -> ind_max=0, max_num=80;
//      x3=x7=FF, all others 00 -> ind_max=3, max_num=FF
//   5. Unsigned: x1=80, all others 7F -> ind_max=1, max_num=80
//   6. rst=1 for one edge with vector 1 applied -> outputs 0/0;
//      rst=0 -> next edge gives 6/F1.
//      With ARGMAX_VALID_EN: in_valid=0 holds the outputs and out_valid drops.

Source files
------------

// File: rtl/argmax_pkg.sv
// Shared widths and the candidate record passed between arg-max compare cells.
package argmax_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned N_IN   = 10;
    localparam int unsigned IDX_W  = 4;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] val;
    } cand_t;

endpackage : argmax_pkg

// File: rtl/argmax_cmp2.sv
// Two-input compare/select cell: keeps the port-a candidate on ties so the lower index wins.
module argmax_cmp2
    import argmax_pkg::*;
(
    input  cand_t a,
    input  cand_t b,
    output cand_t y
);

    assign y = (a.val >= b.val) ? a : b;

endmodule : argmax_cmp2

// File: rtl/argmax_struct.sv
// Registered arg-max over ten unsigned operands, built as a balanced compare tree.
// Optional in_valid/out_valid handshake is enabled by defining ARGMAX_VALID_EN.
module argmax_struct
    import argmax_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
`ifdef ARGMAX_VALID_EN
    input  logic              in_valid,
    output logic              out_valid,
`endif
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    input  logic [DATA_W-1:0] x4,
    input  logic [DATA_W-1:0] x5,
    input  logic [DATA_W-1:0] x6,
    input  logic [DATA_W-1:0] x7,
    input  logic [DATA_W-1:0] x8,
    input  logic [DATA_W-1:0] x9,
    output logic [IDX_W-1:0]  ind_max,
    output logic [DATA_W-1:0] max_num
);

    logic [DATA_W-1:0] xv [N_IN];
    cand_t leaf [N_IN];
    cand_t l1   [5];
    cand_t l2   [2];
    cand_t l3;
    cand_t l4;
    logic  load_c;

    assign xv[0] = x0;
    assign xv[1] = x1;
    assign xv[2] = x2;
    assign xv[3] = x3;
    assign xv[4] = x4;
    assign xv[5] = x5;
    assign xv[6] = x6;
    assign xv[7] = x7;
    assign xv[8] = x8;
    assign xv[9] = x9;

    // Tag each operand with its own index.
    for (genvar i = 0; i < N_IN; i++) begin : g_leaf
        assign leaf[i] = '{idx: IDX_W'(i), val: xv[i]};
    end

    // Level 1: adjacent pairs, lower index on port a.
    for (genvar j = 0; j < 5; j++) begin : g_l1
        argmax_cmp2 u_cmp (.a(leaf[2*j]), .b(leaf[2*j+1]), .y(l1[j]));
    end

    // Level 2: pair 8/9 bypasses this level.
    argmax_cmp2 u_l2_0 (.a(l1[0]), .b(l1[1]), .y(l2[0]));
    argmax_cmp2 u_l2_1 (.a(l1[2]), .b(l1[3]), .y(l2[1]));

    argmax_cmp2 u_l3   (.a(l2[0]), .b(l2[1]), .y(l3));
    argmax_cmp2 u_l4   (.a(l3),    .b(l1[4]), .y(l4));

`ifdef ARGMAX_VALID_EN
    assign load_c = in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end
`else
    assign load_c = 1'b1;
`endif

    // Output registers: reset clears, otherwise capture the tree result when loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            ind_max <= '0;
            max_num <= '0;
        end else if (load_c) begin
            ind_max <= l4.idx;
            max_num <= l4.val;
        end
    end

endmodule : argmax_struct

// File: tb/tb_argmax_struct.sv
// Scoreboard bench for argmax_struct: driver queues reference results, monitor pops and compares.
`timescale 1ns/1ps
module tb_argmax_struct;

    typedef logic [7:0] vec_t [10];

    typedef struct {
        logic [3:0] idx;
        logic [7:0] val;
        logic       ov;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_valid_w;
    logic [7:0] x [10];
    logic [3:0] ind_max;
    logic [7:0] max_num;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: the value the outputs should currently hold.
    logic [3:0] m_idx;
    logic [7:0] m_val;

    always #5 clk = ~clk;

    argmax_struct dut (
        .clk     (clk),
        .rst     (rst),
`ifdef ARGMAX_VALID_EN
        .in_valid(in_valid),
        .out_valid(out_valid_w),
`endif
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]), .x4(x[4]),
        .x5(x[5]), .x6(x[6]), .x7(x[7]), .x8(x[8]), .x9(x[9]),
        .ind_max (ind_max),
        .max_num (max_num)
    );

`ifndef ARGMAX_VALID_EN
    assign out_valid_w = 1'b1;
`endif

    // First position holding the largest value.
    task automatic ref_argmax(input vec_t v, output logic [3:0] idx, output logic [7:0] val);
        int best = 0;
        for (int i = 1; i < 10; i++) begin
            if (v[i] > v[best]) best = i;
        end
        idx = 4'(best);
        val = v[best];
    endtask

    // Drive one operand set for the next edge and queue the expected outputs after it.
    task automatic apply(input string name, input logic r, input vec_t v, input logic vld);
        exp_t e;
        logic [3:0] ci;
        logic [7:0] cv;
        for (int i = 0; i < 10; i++) x[i] = v[i];
        rst      = r;
        in_valid = vld;
        ref_argmax(v, ci, cv);
`ifdef ARGMAX_VALID_EN
        if (r) begin
            m_idx = 4'd0; m_val = 8'd0; e.ov = 1'b0;
        end else begin
            if (vld) begin
                m_idx = ci; m_val = cv;
            end
            e.ov = vld;
        end
`else
        if (r) begin
            m_idx = 4'd0; m_val = 8'd0;
        end else begin
            m_idx = ci; m_val = cv;
        end
        e.ov = 1'b1;
`endif
        e.idx  = m_idx;
        e.val  = m_val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic step(input string name, input logic r, input vec_t v, input logic vld);
        @(posedge clk);
        #2;
        apply(name, r, v, vld);
    endtask

    // Monitor: compare one queued expectation just after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (ind_max !== e.idx || max_num !== e.val || out_valid_w !== e.ov) begin
                    n_errors++;
                    $display("FAIL %s: got idx=%0d val=%02h ov=%b, expected idx=%0d val=%02h ov=%b",
                             e.name, ind_max, max_num, out_valid_w, e.idx, e.val, e.ov);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v1, v2a, v2b, v3, v_all80, v_tie, v_uns, v_zero, vr;
        v1      = '{8'h01, 8'h8F, 8'h49, 8'h09, 8'h8F, 8'h49, 8'hF1, 8'h9F, 8'h69, 8'h4D};
        v2a     = '{8'h05, 8'h8B, 8'hC1, 8'h18, 8'h16, 8'h4D, 8'h61, 8'h99, 8'h8B, 8'h49};
        v2b     = '{8'hB5, 8'h8D, 8'h4D, 8'h0F, 8'h8E, 8'h4A, 8'h03, 8'h9E, 8'h66, 8'h6D};
        v3      = '{8'h01, 8'h0C, 8'h0A, 8'h0D, 8'h0D, 8'h0A, 8'h05, 8'h04, 8'h03, 8'h4D};
        v_tie   = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) begin
            v_all80[i] = 8'h80;
            v_uns[i]   = (i == 1) ? 8'h80 : 8'h7F;
            v_zero[i]  = 8'h00;
        end
        m_idx = 4'd0;
        m_val = 8'd0;

        apply("reset", 1'b1, v1, 1'b1);
        step("reset2",     1'b1, v1, 1'b1);
        step("vec1",       1'b0, v1, 1'b1);
        step("vec2a",      1'b0, v2a, 1'b1);
        step("vec2b",      1'b0, v2b, 1'b1);
        step("last_idx",   1'b0, v3, 1'b1);
        step("tie_all80",  1'b0, v_all80, 1'b1);
        step("tie_3_7",    1'b0, v_tie, 1'b1);
        step("unsigned",   1'b0, v_uns, 1'b1);
        step("all_zero",   1'b0, v_zero, 1'b1);
        step("vec1_again", 1'b0, v1, 1'b1);
        step("mid_reset",  1'b1, v1, 1'b1);
        step("after_rst",  1'b0, v1, 1'b1);
        step("hold_novld", 1'b0, v2b, 1'b0);
        step("hold_novld2",1'b0, v3, 1'b0);
        step("resume",     1'b0, v2a, 1'b1);

        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 10; i++) begin
                // Narrow value range on some vectors to provoke ties.
                if (n % 3 == 0) vr[i] = 8'($urandom_range(0, 3)) + 8'hF0;
                else            vr[i] = 8'($urandom);
            end
            step("random", ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, vr,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_argmax_struct
